jtkcpu_intctl: RTL and testbench
================================

Name: jtkcpu_intctl

Overview:
- Interrupt arbiter and sequencer for the KCPU core. It sits between the external interrupt pins and the microcode sequencer.
- It samples NMI, FIRQ and IRQ, applies the CC masks and NMI arming, and arbitrates by priority.
- At an instruction boundary it hands the winning source to the microcode. It holds the selection and vector address stable until microcode signals that service entry is complete.

Parameters:
- VEC_RST, 16'hFFFE, reset vector address
- VEC_NMI, 16'hFFFC, NMI vector address
- VEC_FIRQ, 16'hFFF6, FIRQ vector address
- VEC_IRQ, 16'hFFF8, IRQ vector address

Ports:
- rst  input  1  synchronous reset, active-high
- clk  input  1  single system clock
- cen  input  1  clock enable; all state advances only when high
- nmi_n  input  1  NMI pin, falling-edge triggered
- firq_n  input  1  FIRQ pin, level, active-low
- irq_n  input  1  IRQ pin, level, active-low
- cc_f  input  1  CC F mask bit; 1 = FIRQ masked
- cc_i  input  1  CC I mask bit; 1 = IRQ masked
- nmi_arm  input  1  pulse: S register written; enables NMI from then on
- ni  input  1  instruction boundary strobe from microcode
- done  input  1  pulse: vector fetched, service entry complete
- intsrv  output  1  an unmasked request is pending (IDLE only)
- int_sel  output  4  one-hot {RST,NMI,FIRQ,IRQ} of the source being serviced
- vec_addr  output  16  vector address of int_sel; 0 when int_sel==0
- busy  output  1  high in states RST and SRV
- nmi_pend  output  1  latched NMI edge awaiting service

Behaviour:
- Reset (rst=1 at posedge, regardless of cen):
  - state=RST, int_sel=4'b1000, vec_addr=VEC_RST, busy=1, intsrv=0.
  - nmi_pend=0, nmi_armed=0.
  - Pin sample registers: nmi_s=1, firq_s=1, irq_s=1.
- Input sampling: on each cen, nmi_s/firq_s/irq_s <= pins. Single register stage, so a pin change is visible to arbitration 1 cen cycle later.
- NMI edge:
  - nmi_fall = nmi_s & ~nmi_n & nmi_armed, evaluated on a cen cycle.
  - nmi_fall sets nmi_pend.
  - Edges while nmi_armed=0 are discarded and never remembered.
  - nmi_armed is set by nmi_arm (on cen) and cleared only by rst.
- Request terms: req_nmi=nmi_pend; req_firq=~firq_s & ~cc_f; req_irq=~irq_s & ~cc_i.
- intsrv = (state==IDLE) & (req_nmi|req_firq|req_irq). Combinational from registers and mask inputs.
- Priority: NMI > FIRQ > IRQ.
- State machine (transitions only on cen):
  - RST: done -> IDLE, int_sel=0. ni is ignored.
  - IDLE: ni & intsrv -> SRV. int_sel latches the highest-priority request; vec_addr latches the matching parameter. ni without a request stays IDLE.
  - Entering SRV with NMI clears nmi_pend in the same cycle. If nmi_fall occurs in that same cycle, set wins and nmi_pend stays 1, so a second NMI is serviced after this one.
  - SRV: int_sel and vec_addr are frozen. Pin or mask changes do not alter them. done -> IDLE, int_sel=0, vec_addr=0.
- Requests are re-evaluated at ni, not at intsrv time. If FIRQ releases before ni, the transition is not taken.
- IRQ and FIRQ are level-only and are not latched. A level must still be present, and unmasked, at ni.
- done in IDLE has no effect. ni in SRV or RST has no effect.
- rst mid-SRV aborts service and returns to the RST state described above; any pending NMI is lost.
- Outputs are registered except intsrv. Latency from ni to int_sel/vec_addr valid is 1 cen cycle.

Test Plan:
- Reset handling: rst high 3 cycles then low -> int_sel=1000, vec_addr=FFFE, busy=1. Pulse done -> int_sel=0, vec_addr=0, busy=0, intsrv=0.
- IRQ masking and service:
  - irq_n=0 with cc_i=1 -> intsrv stays 0 through ni.
  - Drop cc_i=0 -> intsrv=1 next cycle.
  - ni -> int_sel=0001, vec_addr=FFF8.
  - Lowering irq_n further during SRV leaves vec_addr unchanged.
- Priority: firq_n=0, irq_n=0, cc_f=cc_i=0, plus an armed NMI edge; ni -> int_sel=0100, vec_addr=FFFC.
  - done then ni -> int_sel=0010, vec_addr=FFF6.
  - done then ni -> int_sel=0010 again while firq_n is held low.
- NMI arming: falling nmi_n before nmi_arm -> nmi_pend=0, intsrv=0.
  - Pulse nmi_arm, then a falling edge -> nmi_pend=1 one cen later.
  - Holding nmi_n low creates no second edge.
- NMI collision: an NMI edge in the exact cycle of ni entering NMI SRV -> nmi_pend remains 1. After done, intsrv=1 and the next ni gives int_sel=0100 again.
- cen and reset: with cen=0, ni and done are ignored and state is held. rst asserted mid-SRV (int_sel=0010) -> int_sel=1000, nmi_armed=0, nmi_pend=0 on the next clock.

Source files
------------

// File: rtl/jtkcpu_intctl.sv
// jtkcpu_intctl: KCPU interrupt arbiter and microcode entry sequencer
module jtkcpu_intctl #(
   parameter logic [15:0] VEC_RST  = 16'hFFFE,
   parameter logic [15:0] VEC_NMI  = 16'hFFFC,
   parameter logic [15:0] VEC_FIRQ = 16'hFFF6,
   parameter logic [15:0] VEC_IRQ  = 16'hFFF8
) (
   input  logic        rst,
   input  logic        clk,
   input  logic        cen,
   input  logic        nmi_n,
   input  logic        firq_n,
   input  logic        irq_n,
   input  logic        cc_f,
   input  logic        cc_i,
   input  logic        nmi_arm,
   input  logic        ni,
   input  logic        done,
   output logic        intsrv,
   output logic [3:0]  int_sel,
   output logic [15:0] vec_addr,
   output logic        busy,
   output logic        nmi_pend
);
   typedef enum logic [1:0] {ST_RST, ST_IDLE, ST_SRV} state_t;
   state_t      state, state_nx;
   logic [3:0]  sel_nx;
   logic [15:0] vec_nx;
   logic        nmi_s, firq_s, irq_s, nmi_armed;
   logic        nmi_fall, req_nmi, req_firq, req_irq, take;

   assign nmi_fall = nmi_s & ~nmi_n & nmi_armed;
   assign req_nmi  = nmi_pend;
   assign req_firq = ~firq_s & ~cc_f;
   assign req_irq  = ~irq_s & ~cc_i;
   assign intsrv   = (state == ST_IDLE) & (req_nmi | req_firq | req_irq);
   assign busy     = state != ST_IDLE;

   // next state: requests are re-evaluated at ni, selection frozen in SRV
   always_comb begin
      state_nx = state;
      sel_nx   = int_sel;
      vec_nx   = vec_addr;
      take     = 1'b0;
      if (state != ST_IDLE && done) begin
         state_nx = ST_IDLE;
         sel_nx   = 4'b0000;
         vec_nx   = 16'h0000;
      end else if (state == ST_IDLE && ni && intsrv) begin
         take     = 1'b1;
         state_nx = ST_SRV;
         sel_nx   = req_nmi ? 4'b0100 : req_firq ? 4'b0010 : 4'b0001;
         vec_nx   = req_nmi ? VEC_NMI : req_firq ? VEC_FIRQ : VEC_IRQ;
      end
   end

   // registers: pin sampling, NMI edge latch (set beats clear), FSM outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_RST;
         int_sel   <= 4'b1000;
         vec_addr  <= VEC_RST;
         nmi_pend  <= 1'b0;
         nmi_armed <= 1'b0;
         nmi_s     <= 1'b1;
         firq_s    <= 1'b1;
         irq_s     <= 1'b1;
      end else if (cen) begin
         state     <= state_nx;
         int_sel   <= sel_nx;
         vec_addr  <= vec_nx;
         nmi_pend  <= nmi_fall | (nmi_pend & ~(take & req_nmi));
         nmi_armed <= nmi_armed | nmi_arm;
         nmi_s     <= nmi_n;
         firq_s    <= firq_n;
         irq_s     <= irq_n;
      end
   end
endmodule

// File: tb/tb_jtkcpu_intctl.sv
// tb_jtkcpu_intctl: directed vector bench for the interrupt controller
module tb_jtkcpu_intctl;
   logic        rst, clk, cen, nmi_n, firq_n, irq_n, cc_f, cc_i, nmi_arm, ni, done;
   logic        intsrv, busy, nmi_pend;
   logic [3:0]  int_sel;
   logic [15:0] vec_addr;
   int          n_chk = 0, n_pass = 0, n_step = 0;

   typedef struct packed {
      logic [9:0]  in;
      logic        e_int;
      logic [3:0]  e_sel;
      logic [15:0] e_vec;
      logic        e_busy;
      logic        e_pend;
   } vec_t;

   jtkcpu_intctl dut (
      .rst(rst), .clk(clk), .cen(cen), .nmi_n(nmi_n), .firq_n(firq_n),
      .irq_n(irq_n), .cc_f(cc_f), .cc_i(cc_i), .nmi_arm(nmi_arm), .ni(ni),
      .done(done), .intsrv(intsrv), .int_sel(int_sel), .vec_addr(vec_addr),
      .busy(busy), .nmi_pend(nmi_pend)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic vec_t v(input logic [9:0] in, input logic e_int, input logic [3:0] e_sel,
                              input logic [15:0] e_vec, input logic e_busy, input logic e_pend);
      v = '{in: in, e_int: e_int, e_sel: e_sel, e_vec: e_vec, e_busy: e_busy, e_pend: e_pend};
   endfunction

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL step %0d %s: got %h expected %h", n_step, name, act, exp);
   endtask

   // input order: rst cen nmi_n firq_n irq_n cc_f cc_i nmi_arm ni done
   task automatic step(input vec_t t);
      {rst, cen, nmi_n, firq_n, irq_n, cc_f, cc_i, nmi_arm, ni, done} = t.in;
      @(posedge clk);
      #1;
      chk("intsrv",   {15'd0, intsrv},   {15'd0, t.e_int});
      chk("int_sel",  {12'd0, int_sel},  {12'd0, t.e_sel});
      chk("vec_addr", vec_addr,          t.e_vec);
      chk("busy",     {15'd0, busy},     {15'd0, t.e_busy});
      chk("nmi_pend", {15'd0, nmi_pend}, {15'd0, t.e_pend});
      n_step++;
   endtask

   vec_t tbl[23];

   initial begin
      tbl[0]  = v(10'b1111111000, 1'b0, 4'b1000, 16'hFFFE, 1'b1, 1'b0);
      tbl[1]  = v(10'b1111111000, 1'b0, 4'b1000, 16'hFFFE, 1'b1, 1'b0);
      tbl[2]  = v(10'b1111111000, 1'b0, 4'b1000, 16'hFFFE, 1'b1, 1'b0);
      tbl[3]  = v(10'b0111111010, 1'b0, 4'b1000, 16'hFFFE, 1'b1, 1'b0);
      tbl[4]  = v(10'b0111111001, 1'b0, 4'b0000, 16'h0000, 1'b0, 1'b0);
      tbl[5]  = v(10'b0111011000, 1'b0, 4'b0000, 16'h0000, 1'b0, 1'b0);
      tbl[6]  = v(10'b0111011010, 1'b0, 4'b0000, 16'h0000, 1'b0, 1'b0);
      tbl[7]  = v(10'b0111010000, 1'b1, 4'b0000, 16'h0000, 1'b0, 1'b0);
      tbl[8]  = v(10'b0111010010, 1'b0, 4'b0001, 16'hFFF8, 1'b1, 1'b0);
      tbl[9]  = v(10'b0110001000, 1'b0, 4'b0001, 16'hFFF8, 1'b1, 1'b0);
      tbl[10] = v(10'b0111111001, 1'b0, 4'b0000, 16'h0000, 1'b0, 1'b0);
      tbl[11] = v(10'b0101111000, 1'b0, 4'b0000, 16'h0000, 1'b0, 1'b0);
      tbl[12] = v(10'b0111111000, 1'b0, 4'b0000, 16'h0000, 1'b0, 1'b0);
      tbl[13] = v(10'b0111111100, 1'b0, 4'b0000, 16'h0000, 1'b0, 1'b0);
      tbl[14] = v(10'b0101111000, 1'b1, 4'b0000, 16'h0000, 1'b0, 1'b1);
      tbl[15] = v(10'b0101111000, 1'b1, 4'b0000, 16'h0000, 1'b0, 1'b1);
      tbl[16] = v(10'b0100000000, 1'b1, 4'b0000, 16'h0000, 1'b0, 1'b1);
      tbl[17] = v(10'b0100000010, 1'b0, 4'b0100, 16'hFFFC, 1'b1, 1'b0);
      tbl[18] = v(10'b0100000001, 1'b1, 4'b0000, 16'h0000, 1'b0, 1'b0);
      tbl[19] = v(10'b0100000010, 1'b0, 4'b0010, 16'hFFF6, 1'b1, 1'b0);
      tbl[20] = v(10'b0100000001, 1'b1, 4'b0000, 16'h0000, 1'b0, 1'b0);
      tbl[21] = v(10'b0100000010, 1'b0, 4'b0010, 16'hFFF6, 1'b1, 1'b0);
      tbl[22] = v(10'b0111111001, 1'b0, 4'b0000, 16'h0000, 1'b0, 1'b0);
      {rst, cen, nmi_n, firq_n, irq_n, cc_f, cc_i, nmi_arm, ni, done} = 10'b1111111000;
      @(negedge clk);
      for (int i = 0; i < 23; i++) step(tbl[i]);
      // NMI edge in the same cycle as ni entering NMI service: set wins
      step(v(10'b0101111000, 1'b1, 4'b0000, 16'h0000, 1'b0, 1'b1));
      step(v(10'b0111111000, 1'b1, 4'b0000, 16'h0000, 1'b0, 1'b1));
      step(v(10'b0101111010, 1'b0, 4'b0100, 16'hFFFC, 1'b1, 1'b1));
      step(v(10'b0101111001, 1'b1, 4'b0000, 16'h0000, 1'b0, 1'b1));
      step(v(10'b0101111010, 1'b0, 4'b0100, 16'hFFFC, 1'b1, 1'b0));
      step(v(10'b0111111001, 1'b0, 4'b0000, 16'h0000, 1'b0, 1'b0));
      // cen low holds state; rst mid-SRV aborts, drops pending NMI and arming
      step(v(10'b0110101000, 1'b1, 4'b0000, 16'h0000, 1'b0, 1'b0));
      step(v(10'b0010101010, 1'b1, 4'b0000, 16'h0000, 1'b0, 1'b0));
      step(v(10'b0110101010, 1'b0, 4'b0010, 16'hFFF6, 1'b1, 1'b0));
      step(v(10'b0010101001, 1'b0, 4'b0010, 16'hFFF6, 1'b1, 1'b0));
      step(v(10'b0100101000, 1'b0, 4'b0010, 16'hFFF6, 1'b1, 1'b1));
      step(v(10'b1000101000, 1'b0, 4'b1000, 16'hFFFE, 1'b1, 1'b0));
      step(v(10'b0111111001, 1'b0, 4'b0000, 16'h0000, 1'b0, 1'b0));
      step(v(10'b0101111000, 1'b0, 4'b0000, 16'h0000, 1'b0, 1'b0));
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
